// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the 8-bit datapath: fetch, decode, execute, optional
// data-memory wait, writeback. Holds IR, condition flags and the retire counter.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      Instr,
  input  logic [3:0]       ALUFlags,
  input  logic             MemAck,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             RegWrite2,
  output logic             ALUSrc,
  output logic [4:0]       ALUControl,
  output logic             ImmSrc,
  output logic             LM,
  output logic             LI,
  output logic             MemReq,
  output logic             Halted,
  output logic             BusError,
  output logic             Illegal,
  output logic [CNT_W-1:0] RetireCount
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t           state_reg, state_next;
  logic [15:0]      ir_reg;
  logic [3:0]       flags_reg;
  logic [7:0]       tmo_reg, tmo_next;
  logic             bus_err_reg, bus_set;
  logic [CNT_W-1:0] retire_reg;

  logic [4:0] op;
  logic       is_alu, is_mul, is_li, is_lm, is_br, is_halt, is_ill, taken;
  logic       dec_alusrc, dec_immsrc, dec_lm, dec_li;
  logic [4:0] dec_aluctl;
  logic       ctl_on;
  logic       unused_bits;

  assign op      = ir_reg[15:11];
  assign is_alu  = ~op[4];
  assign is_mul  = (op == 5'b01000);
  assign is_li   = (op == 5'b10000);
  assign is_lm   = (op == 5'b10001);
  assign is_br   = (op >= 5'b10010) && (op <= 5'b10101);
  assign is_halt = (op == 5'b11111);
  assign is_ill  = ~(is_alu | is_li | is_lm | is_br | is_halt);

  // Condition bits C (flags_reg[1]) and the register/immediate fields belong to the datapath.
  assign unused_bits = ^{ir_reg[10:8], ir_reg[5:0], flags_reg[1]};

  always_comb begin
    taken = 1'b0;
    case (op)
      5'b10010: taken = 1'b1;
      5'b10011: taken = flags_reg[2];
      5'b10100: taken = ~flags_reg[2];
      5'b10101: taken = flags_reg[3] ^ flags_reg[0];
      default:  taken = 1'b0;
    endcase
  end

  always_comb begin
    dec_alusrc = 1'b0;
    dec_aluctl = 5'd0;
    dec_immsrc = 1'b0;
    dec_lm     = 1'b0;
    dec_li     = 1'b0;
    if (is_alu) begin
      dec_aluctl = op;
      dec_alusrc = ir_reg[6];
    end else if (is_li) begin
      dec_aluctl = 5'b01111;
      dec_alusrc = 1'b1;
      dec_immsrc = 1'b1;
      dec_li     = 1'b1;
    end else if (is_lm) begin
      dec_lm = 1'b1;
    end
  end

  // Datapath steering is only presented while an instruction is in flight.
  assign ctl_on     = (state_reg == S_DECODE) || (state_reg == S_EXEC) ||
                      (state_reg == S_MEM)    || (state_reg == S_WB);
  assign ALUSrc     = ctl_on & dec_alusrc;
  assign ALUControl = ctl_on ? dec_aluctl : 5'd0;
  assign ImmSrc     = ctl_on & dec_immsrc;
  assign LM         = ctl_on & dec_lm;
  assign LI         = ctl_on & dec_li;

  always_comb begin
    state_next = state_reg;
    tmo_next   = tmo_reg;
    bus_set    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    RegWrite   = 1'b0;
    RegWrite2  = 1'b0;
    MemReq     = 1'b0;
    Halted     = 1'b0;
    Illegal    = 1'b0;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (is_alu || is_li) begin
          state_next = S_WB;
        end else if (is_lm) begin
          state_next = S_MEM;
        end else if (is_halt) begin
          state_next = S_HALT;
        end else begin
          PCWrite    = 1'b1;
          PCSrc      = is_br & taken;
          Illegal    = is_ill;
          state_next = S_FETCH;
        end
      end
      S_MEM: begin
        // A timed-out request retires in one extra cycle so PCWrite never
        // depends combinationally on MemAck.
        if (tmo_reg == TMO) begin
          PCWrite    = 1'b1;
          tmo_next   = 8'd0;
          state_next = S_FETCH;
        end else begin
          MemReq = 1'b1;
          if (MemAck) begin
            tmo_next   = 8'd0;
            state_next = S_WB;
          end else begin
            tmo_next = tmo_reg + 8'd1;
            bus_set  = (tmo_reg + 8'd1 == TMO);
          end
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        RegWrite2  = is_alu & is_mul;
        PCWrite    = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  Halted = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      ir_reg      <= 16'd0;
      flags_reg   <= 4'd0;
      tmo_reg     <= 8'd0;
      bus_err_reg <= 1'b0;
      retire_reg  <= '0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      if (state_reg == S_FETCH)
        ir_reg <= Instr;
      if (state_reg == S_EXEC && is_alu && ir_reg[7])
        flags_reg <= ALUFlags;
      if (bus_set)
        bus_err_reg <= 1'b1;
      if (PCWrite)
        retire_reg <= retire_reg + CNT_W'(1);
    end
  end

  assign BusError    = bus_err_reg;
  assign RetireCount = retire_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized checks of multicycle_controller against a per-instruction
// cycle model built from the instruction-class timing rules.
module tb_multicycle_controller;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [15:0]      Instr;
  logic [3:0]       ALUFlags;
  logic             MemAck;
  logic             PCWrite, PCSrc, RegWrite, RegWrite2, ALUSrc;
  logic [4:0]       ALUControl;
  logic             ImmSrc, LM, LI, MemReq, Halted, BusError, Illegal;
  logic [CNT_W-1:0] RetireCount;

  multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemAck(MemAck),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .RegWrite2(RegWrite2),
    .ALUSrc(ALUSrc), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .LM(LM), .LI(LI),
    .MemReq(MemReq), .Halted(Halted), .BusError(BusError), .Illegal(Illegal),
    .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  wire [16:0] obs_vec = {PCWrite, PCSrc, RegWrite, RegWrite2, ALUSrc, ALUControl,
                         ImmSrc, LM, LI, MemReq, Halted, BusError, Illegal};

  int               n_assert = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] m_ret    = '0;
  logic [3:0]       m_flags  = 4'd0;
  logic             m_bus    = 1'b0;

  function automatic logic [16:0] mk(input logic pcw, pcs, rw, rw2, asrc,
                                     input logic [4:0] actl,
                                     input logic imm, lm, li, mreq, hlt, bus, ill);
    return {pcw, pcs, rw, rw2, asrc, actl, imm, lm, li, mreq, hlt, bus, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the retire model.
  task automatic cyc(input logic ack, input logic [16:0] exp_v, input bit frc,
                     input logic [3:0] fval, input string tag, output logic [3:0] fl);
    fl       = frc ? fval : 4'($urandom);
    ALUFlags = fl;
    MemAck   = ack;
    chk({tag, ".ctl"}, 32'(obs_vec), 32'(exp_v));
    chk({tag, ".retire"}, 32'(RetireCount), 32'(m_ret));
    if (exp_v[16]) m_ret = m_ret + 1'b1;
    @(negedge clk);
  endtask

  // Expected behaviour of one instruction from FETCH until it retires (or halts).
  // k: MEM cycle in which MemAck arrives (outside 1..MEM_TIMEOUT means never).
  task automatic run_instr(input logic [15:0] ins, input int k, input bit frc,
                           input logic [3:0] fval);
    logic [4:0] op, actl;
    logic       is_alu, is_li, is_lm, is_br, is_halt, is_ill, taken;
    logic       asrc, imm, acked;
    logic [3:0] fl;
    op      = ins[15:11];
    is_alu  = (op < 5'd16);
    is_li   = (op == 5'd16);
    is_lm   = (op == 5'd17);
    is_br   = (op >= 5'd18) && (op <= 5'd21);
    is_halt = (op == 5'd31);
    is_ill  = !(is_alu || is_li || is_lm || is_br || is_halt);
    asrc    = is_alu ? ins[6] : is_li;
    actl    = is_alu ? op : (is_li ? 5'd15 : 5'd0);
    imm     = is_li;
    acked   = 1'b0;
    case (op)
      5'd18:   taken = 1'b1;
      5'd19:   taken = m_flags[2];
      5'd20:   taken = !m_flags[2];
      5'd21:   taken = m_flags[3] ^ m_flags[0];
      default: taken = 1'b0;
    endcase
    Instr = ins;
    cyc(1'($urandom), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_bus, 1'b0),
        1'b0, 4'd0, "fetch", fl);
    cyc(1'($urandom), mk(1'b0, 1'b0, 1'b0, 1'b0, asrc, actl, imm, is_lm, is_li, 1'b0, 1'b0, m_bus, 1'b0),
        1'b0, 4'd0, "decode", fl);
    cyc(1'($urandom), mk(is_br || is_ill, is_br && taken, 1'b0, 1'b0, asrc, actl, imm, is_lm, is_li,
        1'b0, 1'b0, m_bus, is_ill), frc, fval, "exec", fl);
    if (is_alu && ins[7]) m_flags = fl;
    if (is_lm) begin
      for (int i = 1; i <= MEM_TIMEOUT; i++) begin
        cyc(1'(i == k), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, m_bus, 1'b0),
            1'b0, 4'd0, "mem", fl);
        if (i == k) begin
          acked = 1'b1;
          break;
        end
      end
      if (!acked) begin
        m_bus = 1'b1;
        cyc(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_bus, 1'b0),
            1'b0, 4'd0, "mem_timeout", fl);
      end
    end
    if (is_alu || is_li || acked)
      cyc(1'($urandom), mk(1'b1, 1'b0, 1'b1, is_alu && op == 5'd8, asrc, actl, imm, is_lm, is_li,
          1'b0, 1'b0, m_bus, 1'b0), 1'b0, 4'd0, "wb", fl);
    $display("instr %h op %0d k %0d retired %0d flags %b buserr %0d",
             ins, op, k, m_ret, m_flags, m_bus);
  endtask

  initial begin
    logic [3:0]  fl;
    logic [4:0]  rop;
    logic [15:0] rins;
    reset    = 1'b1;
    Instr    = 16'd0;
    ALUFlags = 4'd0;
    MemAck   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.ctl", 32'(obs_vec), 32'd0);
    chk("reset.retire", 32'(RetireCount), 32'd0);
    reset = 1'b0;

    run_instr(16'h0112, 0, 1'b0, 4'd0);       // ADD r1,r2
    chk("add.retire", 32'(RetireCount), 32'd1);
    run_instr(16'h0980, 0, 1'b1, 4'b0100);    // SUBS, Z set
    run_instr(16'h9820, 0, 1'b0, 4'd0);       // BEQ taken
    run_instr(16'h0980, 0, 1'b1, 4'b0000);    // SUBS, Z clear
    run_instr(16'h9820, 0, 1'b0, 4'd0);       // BEQ not taken
    run_instr(16'h4312, 0, 1'b0, 4'd0);       // MUL
    run_instr(16'h8345, 0, 1'b0, 4'd0);       // LI
    run_instr(16'h8800, 3, 1'b0, 4'd0);       // LM, ack in 3rd MEM cycle
    run_instr(16'h8800, 0, 1'b0, 4'd0);       // LM, never acked
    run_instr(16'h8800, MEM_TIMEOUT, 1'b0, 4'd0);  // ack on the timeout cycle wins
    run_instr(16'hC000, 0, 1'b0, 4'd0);       // undefined opcode

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rop = 5'($urandom_range(0, 15));
        4:          rop = 5'd16;
        5:          rop = 5'd17;
        6, 7, 8:    rop = 5'($urandom_range(18, 21));
        default:    rop = 5'($urandom_range(22, 30));
      endcase
      rins = {rop, 11'($urandom)};
      run_instr(rins, int'($urandom_range(1, MEM_TIMEOUT + 3)), 1'b0, 4'd0);
    end

    // Reset while a load is waiting in MEM.
    Instr = 16'h8800;
    cyc(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_bus, 1'b0), 1'b0, 4'd0, "rst.fetch", fl);
    cyc(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_bus, 1'b0), 1'b0, 4'd0, "rst.decode", fl);
    cyc(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_bus, 1'b0), 1'b0, 4'd0, "rst.exec", fl);
    cyc(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, m_bus, 1'b0), 1'b0, 4'd0, "rst.mem", fl);
    reset = 1'b1;
    chk("rst.memreq_before", 32'(MemReq), 32'd1);
    @(negedge clk);
    m_ret   = '0;
    m_flags = 4'd0;
    m_bus   = 1'b0;
    chk("rst.ctl_after", 32'(obs_vec), 32'd0);
    chk("rst.retire_after", 32'(RetireCount), 32'd0);
    reset = 1'b0;
    $display("reset during MEM applied");

    run_instr(16'h0045, 0, 1'b0, 4'd0);       // one ALU op so the halt check sees a nonzero count
    run_instr(16'hF800, 0, 1'b0, 4'd0);       // HALT
    for (int n = 0; n < 100; n++)
      cyc(1'($urandom), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_bus, 1'b0),
          1'b0, 4'd0, "halt", fl);
    $display("halted for 100 cycles, retired %0d", m_ret);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle FSM controller that sequences the 8-bit datapath one instruction at a time: fetch, decode, execute, optional memory wait, writeback.
- Drives every datapath control input.
- Holds the condition-flag register and a retired-instruction counter.
- Provides the enable for the datapath PC register (PCWrite), and a request/acknowledge handshake to data memory for LM.

Parameters:
- MEM_TIMEOUT, 15, max cycles in MEM waiting for MemAck before bus error (1..255).
- CNT_W, 16, width of RetireCount.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Instr  input  16  current instruction from instruction memory (stable while PC unchanged).
- ALUFlags  input  4  datapath flags {N,Z,C,V} = [3:0].
- MemAck  input  1  data memory acknowledge, one-cycle pulse.
- PCWrite  output  1  PC register enable.
- PCSrc  output  1  1 selects branch target Instr[7:0].
- RegWrite  output  1  write Result to destination register.
- RegWrite2  output  1  write ALUResult2 (MUL high byte).
- ALUSrc  output  1  1 selects ExtImm as SrcB.
- ALUControl  output  5  ALU operation code.
- ImmSrc  output  1  0: 3-bit imm Instr[2:0]; 1: 8-bit imm Instr[7:0].
- LM  output  1  load-memory select (result mux, DataAdr).
- LI  output  1  load-immediate destination select (Instr[10:8]).
- MemReq  output  1  data memory request, held until MemAck.
- Halted  output  1  core stopped.
- BusError  output  1  sticky; set on MEM timeout.
- Illegal  output  1  one-cycle pulse on undefined opcode.
- RetireCount  output  CNT_W  instructions retired since reset.

Behaviour:
- Reset (synchronous): all outputs 0, state FETCH, IR 0, flags 0, timeout counter 0, RetireCount 0. Reset asserted in any state (including MEM with MemReq high) takes effect at that edge; MemReq drops the next cycle.
- IR: Instr latched into IR at the end of FETCH. opcode = IR[15:11].
- Decode:
  - 00000–01111 ALU op: ALUControl = opcode; IR[6]=1 selects immediate (ALUSrc=1, ImmSrc=0); IR[7]=S updates flags.
  - 01000 is MUL and additionally asserts RegWrite2.
  - 10000 LI: LI=1, ALUSrc=1, ImmSrc=1, ALUControl=01111 (pass B).
  - 10001 LM.
  - 10010 B; 10011 BEQ (Z); 10100 BNE (!Z); 10101 BLT (N^V).
  - 11111 HALT.
  - Others: Illegal, treated as NOP.
- States: FETCH -> DECODE -> EXEC -> {WB | MEM | FETCH | HALT}. Halted=1 in HALT.
- Control timing: ALUControl/ALUSrc/ImmSrc/LI/LM are valid from DECODE through WB and 0 in FETCH.
- EXEC:
  - ALU with S=1: flags <= ALUFlags at the end of EXEC.
  - Branch: PCWrite=1, PCSrc=taken, using flags as held at entry to EXEC (not updated by this instruction) -> FETCH.
  - NOP/illegal: PCWrite=1, PCSrc=0 -> FETCH.
  - HALT -> HALT, no PCWrite.
  - ALU/LI -> WB. LM -> MEM.
- MEM:
  - MemReq=1, timeout counter increments each cycle.
  - MemAck -> WB.
  - Counter reaching MEM_TIMEOUT without ack: BusError<=1, PCWrite=1, no register write -> FETCH.
  - MemAck in the same cycle as timeout: ack wins.
  - MemAck outside MEM is ignored.
- WB: RegWrite=1 (plus RegWrite2 for MUL), PCWrite=1, PCSrc=0 -> FETCH.
- Retire: RetireCount increments on each PCWrite cycle (retire), wraps at 2^CNT_W.
- Latency:
  - ALU/LI: 4 cycles.
  - Branch/NOP: 3 cycles.
  - LM: 4 + k cycles, where MemAck arrives k cycles after MEM entry (k >= 1).
- HALT is left only by reset.
- Control outputs are decoded from registered state/IR; no combinational path from ALUFlags or MemAck to any output.

Test Plan:
- ADD r1,r2 (opcode 00000, IR[6]=0) after reset -> FETCH, DECODE, EXEC, WB; RegWrite=1 only in cycle 4, PCWrite=1 cycle 4, RetireCount=1.
- SUBS (S=1) with ALUFlags=0100, then BEQ 0x20 -> branch EXEC has PCSrc=1, PCWrite=1; repeat with ALUFlags=0000 -> PCSrc=0.
- MUL (01000) -> RegWrite and RegWrite2 both 1 in WB only.
- LM with MemAck 3 cycles after MEM entry -> MemReq high 3 cycles, then WB with LM=1, RegWrite=1.
- LM with no MemAck -> after 15 MEM cycles BusError=1, no RegWrite, PCWrite=1.
- Reset asserted mid-MEM -> next cycle MemReq=0, state FETCH, RetireCount=0. HALT (11111) -> Halted=1, PCWrite stays 0 for 100 cycles. Opcode 11000 -> Illegal pulses for 1 cycle, PC advances.
